// File: rtl/bt656_sync_decoder.sv
// BT.656 receive timing decoder: EAV/SAV parsing, XY check, H/V/F, counters and line lock.
// Optional build macro BT656_XY_CORRECT_EN enables single-bit XY correction.
module bt656_sync_decoder #(
  parameter int LINE_SIZE  = 1716,
  parameter int LINE_COUNT = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  bt656_stream_in,
  output logic [9:0]  video_out,
  output logic        active_valid,
  output logic        H,
  output logic        V,
  output logic        F,
  output logic [10:0] h_count,
  output logic [9:0]  line_count,
  output logic        timing_code,
  output logic        sync_error,
  output logic        timing_locked,
  output logic [1:0]  lock_state
);

  // Streaming interface: no valid/ready handshake. One word is accepted every clk and
  // every output describes the word currently on video_out. lock_state: 0 search, 1 track, 2 locked.
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int SW = $clog2(LINE_SIZE + 5);
  localparam int RW = $clog2(LOCK_LINES + 1);
  localparam logic [SW-1:0] SPACING   = SW'(LINE_SIZE);
  localparam logic [SW-1:0] TIMEOUT   = SW'(LINE_SIZE + 4);
  localparam logic [10:0]   H_LAST    = 11'(LINE_SIZE - 1);
  localparam logic [9:0]    LINE_LAST = 10'(LINE_COUNT - 1);
  localparam logic [RW-1:0] RUN_LOCK  = RW'(LOCK_LINES);

  logic [9:0]    s0, s1, s2, s3;
  logic [3:0]    calc_p, syndrome;
  logic          xy_ok, xy_f, xy_v, xy_h;
  logic          pre_code;
  logic          det_q, dq_ok, dq_f, dq_v, dq_h;
  logic          eav_ok, sav_ok;
  logic [3:0]    code_sr;
  logic          act_en;
  logic [SW-1:0] since_eav;
  logic [RW-1:0] run, run_next;
  logic [1:0]    lock_next;

  // XY decode runs on the incoming word one cycle before its preamble reaches video_out,
  // so every registered output lines up with video_out without extra delay.
  always_comb begin
    calc_p   = {bt656_stream_in[7] ^ bt656_stream_in[6],
                bt656_stream_in[8] ^ bt656_stream_in[6],
                bt656_stream_in[8] ^ bt656_stream_in[7],
                bt656_stream_in[8] ^ bt656_stream_in[7] ^ bt656_stream_in[6]};
    syndrome = bt656_stream_in[5:2] ^ calc_p;
    xy_f     = bt656_stream_in[8];
    xy_v     = bt656_stream_in[7];
    xy_h     = bt656_stream_in[6];
`ifdef BT656_XY_CORRECT_EN
    xy_ok    = bt656_stream_in[9];
    case (syndrome)
      4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
      end
      4'b0111: xy_f = ~bt656_stream_in[8];
      4'b1011: xy_v = ~bt656_stream_in[7];
      4'b1101: xy_h = ~bt656_stream_in[6];
      default: xy_ok = 1'b0;
    endcase
`else
    xy_ok    = bt656_stream_in[9] && (syndrome == 4'b0000);
`endif
  end

  assign pre_code = (s2 == 10'h3FF) && (s1 == 10'h000) && (s0 == 10'h000);

  // det_q is high exactly when the preamble 3FF sits on video_out.
  assign eav_ok = det_q && dq_ok && dq_h;
  assign sav_ok = det_q && dq_ok && !dq_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0      <= 10'h000;
      s1      <= 10'h000;
      s2      <= 10'h000;
      s3      <= 10'h000;
      det_q   <= 1'b0;
      dq_ok   <= 1'b0;
      dq_f    <= 1'b0;
      dq_v    <= 1'b0;
      dq_h    <= 1'b0;
      code_sr <= 4'b0000;
    end else begin
      s0      <= bt656_stream_in;
      s1      <= s0;
      s2      <= s1;
      s3      <= s2;
      det_q   <= pre_code;
      dq_ok   <= xy_ok;
      dq_f    <= xy_f;
      dq_v    <= xy_v;
      dq_h    <= xy_h;
      code_sr <= {code_sr[2:0], pre_code};
    end
  end

  assign video_out    = s3;
  assign timing_code  = |code_sr;
  assign active_valid = act_en && !timing_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count    <= 11'd0;
      line_count <= 10'd0;
      H          <= 1'b0;
      V          <= 1'b0;
      F          <= 1'b0;
      act_en     <= 1'b0;
      sync_error <= 1'b0;
      since_eav  <= '0;
    end else begin
      // An EAV arriving on the wrap cycle still yields a single zero.
      if (pre_code && xy_ok && xy_h)
        h_count <= 11'd0;
      else if (h_count == H_LAST)
        h_count <= 11'd0;
      else
        h_count <= h_count + 11'd1;

      sync_error <= det_q && !dq_ok;

      if (det_q && dq_ok) begin
        F <= dq_f;
        V <= dq_v;
        H <= dq_h;
      end

      if (eav_ok)
        act_en <= 1'b0;
      else if (sav_ok)
        act_en <= !dq_v;

      // F here is still the previous code's field bit: 1->0 marks frame start.
      if (eav_ok) begin
        if (F && !dq_f)
          line_count <= 10'd0;
        else if (line_count != LINE_LAST)
          line_count <= line_count + 10'd1;
      end

      if (eav_ok)
        since_eav <= SW'(1);
      else if (since_eav != TIMEOUT)
        since_eav <= since_eav + SW'(1);
    end
  end

  // A bad XY drops lock even if it would otherwise have advanced the run.
  always_comb begin
    lock_next = lock_state;
    run_next  = run;
    case (lock_state)
      ST_SEARCH: begin
        if (eav_ok) begin
          lock_next = ST_TRACK;
          run_next  = RW'(1);
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (det_q && !dq_ok) begin
          lock_next = ST_SEARCH;
        end else if (eav_ok) begin
          if (since_eav != SPACING) begin
            lock_next = ST_SEARCH;
          end else if (lock_state == ST_TRACK) begin
            run_next = run + RW'(1);
            if (run_next == RUN_LOCK)
              lock_next = ST_LOCKED;
          end
        end else if (since_eav == TIMEOUT) begin
          lock_next = ST_SEARCH;
        end
      end
      default: lock_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= ST_SEARCH;
      run        <= '0;
    end else begin
      lock_state <= lock_next;
      run        <= run_next;
    end
  end

  assign timing_locked = (lock_state == ST_LOCKED);

endmodule

// File: tb/tb_bt656_sync_decoder.sv
// Bench for bt656_sync_decoder: random BT.656 traffic, reference model, expected queue, monitor.
// Honours BT656_XY_CORRECT_EN in its model when the design is built with it.
module tb_bt656_sync_decoder;
  localparam int LINE_SIZE  = 1716;
  localparam int LINE_COUNT = 525;
  localparam int LOCK_LINES = 4;
  localparam int EW = 39;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  bt656_stream_in;
  logic [9:0]  video_out;
  logic        active_valid, H, V, F;
  logic [10:0] h_count;
  logic [9:0]  line_count;
  logic        timing_code, sync_error, timing_locked;
  logic [1:0]  lock_state;

  always #5 clk = ~clk;

  bt656_sync_decoder #(.LINE_SIZE(LINE_SIZE), .LINE_COUNT(LINE_COUNT), .LOCK_LINES(LOCK_LINES)) dut (
    .clk(clk), .reset(reset), .bt656_stream_in(bt656_stream_in),
    .video_out(video_out), .active_valid(active_valid), .H(H), .V(V), .F(F),
    .h_count(h_count), .line_count(line_count), .timing_code(timing_code),
    .sync_error(sync_error), .timing_locked(timing_locked), .lock_state(lock_state)
  );

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the word history since reset release plus a few remembered facts
  logic [9:0] hist[$];
  bit m_last_sav, m_f, m_v, m_h, m_err_pend;
  int m_href, m_line, m_lock, m_run, m_last_eav;

  function automatic logic [9:0] xy_of(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic bit xy_clean(input logic [9:0] x);
    return x[9] && (x[5:2] == {x[7] ^ x[6], x[8] ^ x[6], x[8] ^ x[7], x[8] ^ x[7] ^ x[6]});
  endfunction

  function automatic void xy_decode(input logic [9:0] x, output bit ok, output logic [9:0] fx);
    logic [9:0] t;
    ok = xy_clean(x);
    fx = x;
`ifdef BT656_XY_CORRECT_EN
    if (!ok && x[9]) begin
      for (int b = 2; b <= 8; b++) begin
        t = x ^ (10'd1 << b);
        if (xy_clean(t)) begin
          ok = 1'b1;
          fx = t;
        end
      end
    end
`endif
  endfunction

  function automatic logic [9:0] hw(input int i);
    if (i < 0 || i >= hist.size()) return 10'h000;
    return hist[i];
  endfunction

  function automatic bit code_at(input int i);
    return (hw(i) == 10'h3FF) && (hw(i + 1) == 10'h000) && (hw(i + 2) == 10'h000);
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_last_sav = 0; m_f = 0; m_v = 0; m_h = 0; m_err_pend = 0;
    m_href = -4; m_line = 0; m_lock = 0; m_run = 0; m_last_eav = 0;
  endfunction

  function automatic string fmt(input logic [EW-1:0] b);
    return $sformatf("vid=%h av=%b H=%b V=%b F=%b hc=%0d ln=%0d tc=%b se=%b lk=%b srch=%b",
                     b[38:29], b[28], b[27], b[26], b[25], b[24:14], b[13:4], b[3], b[2], b[1], b[0]);
  endfunction

  // Drive one word (or a reset cycle) and queue what the outputs must be after the next edge.
  task automatic step(input logic [9:0] w, input bit r);
    logic [EW-1:0] e;
    logic [9:0] fx;
    int j;
    bit cj, ok, tc;
    @(negedge clk);
    reset = r;
    bt656_stream_in = w;
    if (r) begin
      model_reset();
      e = '0;
      e[0] = 1'b1;
    end else begin
      hist.push_back(w);
      j = hist.size() - 4;
      cj = code_at(j);
      ok = 0;
      fx = '0;
      if (cj) xy_decode(hw(j + 3), ok, fx);
      if (cj && ok && fx[6]) m_href = j;
      tc = code_at(j) || code_at(j - 1) || code_at(j - 2) || code_at(j - 3);
      e = {hw(j), (m_last_sav && !m_v && !tc), m_h, m_v, m_f,
           11'((j - m_href) % LINE_SIZE), 10'(m_line), tc, m_err_pend,
           (m_lock == 2), (m_lock == 0)};
      m_err_pend = cj && !ok;
      if (cj && !ok) begin
        m_lock = 0;
      end else if (cj && ok) begin
        if (fx[6]) begin
          if (m_f && !fx[8]) m_line = 0;
          else if (m_line < LINE_COUNT - 1) m_line++;
          if (m_lock == 0) begin
            m_lock = 1;
            m_run = 1;
          end else if (j - m_last_eav != LINE_SIZE) begin
            m_lock = 0;
          end else if (m_lock == 1) begin
            m_run++;
            if (m_run == LOCK_LINES) m_lock = 2;
          end
          m_last_eav = j;
        end
        m_last_sav = !fx[6];
        m_f = fx[8]; m_v = fx[7]; m_h = fx[6];
      end else if (m_lock != 0 && j - m_last_eav >= LINE_SIZE + 4) begin
        m_lock = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send_code(input logic [9:0] xy);
    step(10'h3FF, 0); step(10'h000, 0); step(10'h000, 0); step(xy, 0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(i[0] ? 10'h040 : 10'h200, 0);
  endtask

  task automatic active(input int n);
    for (int i = 0; i < n; i++) step(10'($urandom_range(10'h040, 10'h3C0)), 0);
  endtask

  // kind: 0 normal, 1 EAV with bad_xy, 2 EAV replaced by zeros, 3 EAV late by one word
  task automatic send_line(input bit f, input bit v, input int kind, input logic [9:0] bad_xy);
    if (kind == 3) step(10'h040, 0);
    if (kind == 2) repeat (4) step(10'h000, 0);
    else send_code(kind == 1 ? bad_xy : xy_of(f, v, 1'b1));
    blank(268);
    send_code(xy_of(f, v, 1'b0));
    active(1440);
  endtask

  task automatic random_segment();
    logic [9:0] xy;
    int len, pick;
    if ($urandom_range(0, 3) == 0) begin
      xy = xy_of(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) xy = xy ^ (10'd1 << $urandom_range(2, 9));
      send_code(xy);
    end else begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        pick = $urandom_range(0, 5);
        if (pick == 0) step(10'h3FF, 0);
        else if (pick == 1) step(10'h000, 0);
        else step(10'($urandom_range(0, 1023)), 0);
      end
    end
  endtask

  initial begin : monitor
    logic [EW-1:0] act, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {video_out, active_valid, H, V, F, h_count, line_count,
               timing_code, sync_error, timing_locked, (lock_state == 2'd0)};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got: %s | want: %s", $time, fmt(act), fmt(e));
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    bt656_stream_in = 10'h000;
    model_reset();
    repeat (10) step(10'h000, 1);
    blank(20);
    for (int i = 0; i < 10; i++) send_line(1'b0, (i < 2), 0, 10'h000);
    repeat (3) send_line(1'b1, 1'b0, 0, 10'h000);
    repeat (2) send_line(1'b0, 1'b0, 0, 10'h000);
    send_line(1'b0, 1'b0, 1, 10'h27C);
    repeat (5) send_line(1'b0, 1'b0, 0, 10'h000);
    send_line(1'b0, 1'b0, 2, 10'h000);
    repeat (5) send_line(1'b0, 1'b0, 0, 10'h000);
    send_line(1'b0, 1'b0, 3, 10'h000);
    repeat (5) send_line(1'b0, 1'b0, 0, 10'h000);
    send_code(xy_of(1'b0, 1'b0, 1'b1));
    blank(268);
    send_code(xy_of(1'b0, 1'b0, 1'b0));
    active(700);
    step(10'h155, 1);
    blank(10);
    repeat (2) send_line(1'b0, 1'b0, 0, 10'h000);
    for (int i = 0; i < 540; i++) begin
      send_code(xy_of(1'b0, 1'b1, 1'b1));
      blank(4);
    end
    send_code(xy_of(1'b1, 1'b1, 1'b1));
    blank(4);
    send_code(xy_of(1'b0, 1'b1, 1'b1));
    blank(4);
    for (int i = 0; i < 300; i++) random_segment();
    blank(8);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
